// File: rtl/endec_result_deframer.sv
// Collects one 11-beat AXI4-Stream result packet into a shadow buffer and presents the
// encoder/decoder results as registered words with a valid/ready handshake and length-error pulses.
module endec_result_deframer #(
  parameter int DATA_W = 64,
  parameter int ENC_W  = 576,
  parameter int DEC_W  = 128,
  parameter int BEATS  = (ENC_W + DEC_W) / DATA_W
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  output logic                s_axis_tready,
  output logic [ENC_W-1:0]    o_encoder_data,
  output logic [DEC_W-1:0]    o_decoder_data,
  output logic                o_valid,
  input  logic                i_ready,
  output logic                o_err_short,
  output logic                o_err_long,
  output logic [15:0]         o_frame_cnt
);

  localparam int PKT_W = ENC_W + DEC_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  if (BEATS * DATA_W != PKT_W) begin : g_bad_geometry
    $error("endec_result_deframer: ENC_W+DEC_W must equal BEATS*DATA_W");
  end

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic [PKT_W-1:0]   shadow_q,    shadow_d;
  logic [ENC_W-1:0]   enc_q,       enc_d;
  logic [DEC_W-1:0]   dec_q,       dec_d;
  logic               valid_q,     valid_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q,  err_long_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;

  logic               at_last;
  logic               stall;
  logic               accept;
  logic [PKT_W-1:0]   merged;

  // Only the final beat is held back, and only while the previous result is unconsumed.
  always_comb begin
    at_last       = (cnt_q == LAST_BEAT);
    stall         = (state_q == COLLECT) && at_last && valid_q && !i_ready;
    s_axis_tready = rst_n && !stall;
    accept        = s_axis_tvalid && s_axis_tready;
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    enc_d       = enc_q;
    dec_d       = dec_q;
    frame_cnt_d = frame_cnt_q;
    valid_d     = valid_q && !i_ready;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;

    merged = shadow_q;
    merged[PKT_W-1 -: DATA_W] = s_axis_tdata;

    if (accept) begin
      unique case (state_q)
        COLLECT: begin
          if (!at_last) begin
            if (s_axis_tlast) begin
              cnt_d       = '0;
              err_short_d = 1'b1;
            end else begin
              for (int k = 0; k < BEATS - 1; k++) begin
                if (cnt_q == CNT_W'(k)) shadow_d[k*DATA_W +: DATA_W] = s_axis_tdata;
              end
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (s_axis_tlast) begin
            // Load wins over the consumer's clear, giving back-to-back results with no bubble.
            enc_d       = merged[ENC_W-1:0];
            dec_d       = merged[PKT_W-1 -: DEC_W];
            valid_d     = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            cnt_d       = '0;
          end else begin
            err_long_d = 1'b1;
            state_d    = DRAIN;
          end
        end
        DRAIN: begin
          if (s_axis_tlast) begin
            cnt_d   = '0;
            state_d = COLLECT;
          end
        end
        default: state_d = COLLECT;
      endcase
    end
  end

  // NOTE: the wide result and shadow registers are reset too, so a reset never exposes stale data.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      shadow_q    <= '0;
      enc_q       <= '0;
      dec_q       <= '0;
      valid_q     <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop updating from the same pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      enc_q       <= enc_d;
      dec_q       <= dec_d;
      valid_q     <= valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_encoder_data = enc_q;
  assign o_decoder_data = dec_q;
  assign o_valid        = valid_q;
  assign o_err_short    = err_short_q;
  assign o_err_long     = err_long_q;
  assign o_frame_cnt    = frame_cnt_q;

endmodule

// File: doc/endec_result_deframer.md
Name: endec_result_deframer

Overview:
- Downstream consumer of the endec_interface AXI4-Stream master port.
- Collects one 11-beat, 64-bit result packet: 576-bit encoder output followed by 128-bit decoder output.
- Presents both results as parallel registered words with a valid/ready handshake, and flags malformed packet lengths.
- Uses a shadow buffer so the next packet can stream in while the previous result is held.

Parameters:
- DATA_W, 64, AXI-Stream data width.
- ENC_W, 576, encoder result width (low part of the packet).
- DEC_W, 128, decoder result width (high part of the packet).
- BEATS, (ENC_W+DEC_W)/DATA_W = 11, beats per legal packet. ENC_W+DEC_W must be a multiple of DATA_W.

Ports:
- sys_clk  in  1  single clock for all logic
- rst_n  in  1  synchronous reset, active-low
- s_axis_tdata  in  DATA_W  result stream data
- s_axis_tvalid  in  1  stream valid
- s_axis_tlast  in  1  last beat of packet
- s_axis_tready  out  1  stream ready
- o_encoder_data  out  ENC_W  assembled encoder result
- o_decoder_data  out  DEC_W  assembled decoder result
- o_valid  out  1  result words valid
- i_ready  in  1  consumer accepts the result
- o_err_short  out  1  1-cycle pulse: tlast arrived before beat BEATS-1
- o_err_long  out  1  1-cycle pulse: beat BEATS-1 had no tlast
- o_frame_cnt  out  16  count of good packets, wraps at 0xFFFF->0

Behaviour:
- Reset (rst_n=0 at a sys_clk edge):
  - o_valid, o_err_*, o_frame_cnt, beat counter: 0.
  - o_encoder_data, o_decoder_data, shadow buffer: 0.
  - State: COLLECT.
  - s_axis_tready is forced 0 combinationally while rst_n=0.
- Beat acceptance: a beat is accepted on an edge where s_axis_tvalid & s_axis_tready = 1.
- Beat mapping: accepted beat k (k = 0..BEATS-1) writes shadow[64k+63:64k].
  - o_encoder_data = word[575:0].
  - o_decoder_data = word[703:576].
- State COLLECT:
  - tready = 1, except when beat counter = BEATS-1, o_valid = 1 and i_ready = 0. This stalls only the final beat while the previous result is still unconsumed.
  - Beat with count < BEATS-1 and tlast=0: store the beat, count+1.
  - Beat with count < BEATS-1 and tlast=1: discard the packet, count <- 0, o_err_short pulses on the next cycle, stay in COLLECT.
  - Beat with count = BEATS-1 and tlast=1:
    - Load o_encoder_data/o_decoder_data from the shadow buffer with this beat merged in.
    - o_valid <- 1, o_frame_cnt+1, count <- 0.
    - The result is visible one edge after the final-beat handshake (latency 1 cycle from the last beat).
  - Beat with count = BEATS-1 and tlast=0: discard, o_err_long pulses, go to DRAIN.
- State DRAIN:
  - tready = 1; accepted beats are discarded.
  - On an accepted beat with tlast=1: count <- 0, go to COLLECT.
  - No further error pulses while in DRAIN.
- Output handshake:
  - o_valid clears on an edge with o_valid & i_ready, unless a new final beat completes on the same edge. In that case o_valid stays 1 and the outputs load the new result (back-to-back, no bubble).
  - o_encoder_data/o_decoder_data are stable while o_valid=1 and i_ready=0.
- tvalid gaps: deasserting tvalid mid-packet holds count and shadow contents; there is no timeout.
- Error pulses never assert o_valid and never disturb the held output.
- Reset mid-packet: partial data is dropped and the next packet starts at beat 0.

Test Plan:
- Beat k = 64'h0000_0000_0000_0100 + k, k = 0..10, tlast on beat 10, i_ready=1 -> o_valid high 1 cycle after beat 10; o_encoder_data[63:0] = 64'h100; o_decoder_data[127:64] = 64'h10A; o_frame_cnt = 1.
- Two back-to-back packets (all-0xAA, then all-0x55 beats) with i_ready=0 until cycle 30:
  - -> tready drops only at the second packet's beat 10; outputs stay 0xAA pattern.
  - -> one cycle after i_ready=1, the second packet's final beat is accepted; the next edge shows the 0x55 pattern with o_valid=1 throughout.
- Packet of 6 beats with tlast on beat 5, then a legal packet -> o_err_short pulses once; no o_valid for the short packet; the legal packet is assembled correctly (o_frame_cnt = 1).
- Packet of 13 beats, tlast on beat 12, then a legal packet -> o_err_long pulses once at beat 10; beats 11–12 are discarded; the following packet is received correctly.
- Legal packet with tvalid low for 3 cycles between each beat -> same result as the first scenario; count never advances on tvalid=0.
- rst_n=0 for 1 cycle after beat 4, then a full legal packet -> no o_valid from the partial packet; tready=0 during reset; the new packet maps from beat 0; o_frame_cnt = 1.
